// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes: one 32-bit column per cycle through four inverse S-box ROMs.
// Define INV_SUB_BYTES_PARALLEL_EN to convert all 16 bytes in a single BUSY cycle instead.
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] new_block
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // FIPS-197 inverse S-box, entry 0 in the most significant byte of the first row.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    fsm_t         fsm;
    logic [1:0]   col;
    logic [127:0] state;
    logic [127:0] state_nxt;
    logic         last;

`ifdef INV_SUB_BYTES_PARALLEL_EN
    always_comb begin
        state_nxt = state;
        for (int i = 0; i < 16; i++) begin
            state_nxt[127 - 8*i -: 8] = inv_sbox(state[127 - 8*i -: 8]);
        end
    end

    assign last = 1'b1;
`else
    logic [31:0] col_in;
    logic [31:0] col_out;

    // Column mux in, four ROMs, column demux back into the same slot.
    always_comb begin
        case (col)
            2'd0:    col_in = state[127:96];
            2'd1:    col_in = state[95:64];
            2'd2:    col_in = state[63:32];
            default: col_in = state[31:0];
        endcase
        col_out = {inv_sbox(col_in[31:24]), inv_sbox(col_in[23:16]),
                   inv_sbox(col_in[15:8]),  inv_sbox(col_in[7:0])};
        state_nxt = state;
        case (col)
            2'd0:    state_nxt[127:96] = col_out;
            2'd1:    state_nxt[95:64]  = col_out;
            2'd2:    state_nxt[63:32]  = col_out;
            default: state_nxt[31:0]   = col_out;
        endcase
    end

    assign last = (col == 2'd3);
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid/data hold until ready. in_ready depends only on fsm and, in DONE, on out_ready.
    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign out_valid = (fsm == DONE);

    // new_block is a separate register so it only moves when a result lands in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            col       <= 2'd0;
            state     <= 128'h0;
            new_block <= 128'h0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state <= block;
                        col   <= 2'd0;
                        fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    state <= state_nxt;
                    col   <= col + 2'd1;
                    if (last) begin
                        new_block <= state_nxt;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state <= block;
                            col   <= 2'd0;
                            fsm   <= BUSY;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
